registers_dump: RTL
===================

REGISTERS_DUMP -- requirements
Module: Registers_Dump

Interface
REQ-001 Parameter ADDR_W, default 6, register-address width; the bank holds 2^ADDR_W registers.
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-006 Abort  input  1  terminates any dump in progress.
REQ-007 First_Reg  input  ADDR_W  first register to dump; sampled with Start.
REQ-008 Last_Reg  input  ADDR_W  last register to dump; sampled with Start.
REQ-009 Read_Register  output  ADDR_W  registered read address driven to the bank's read port.
REQ-010 Read_Data  input  DATA_W  combinational read data returned by the bank for Read_Register.
REQ-011 Dump_Data  output  DATA_W  captured register value.
REQ-012 Dump_Addr  output  ADDR_W  register index of Dump_Data.
REQ-013 Dump_Valid  output  1  Dump_Data and Dump_Addr are valid.
REQ-014 Dump_Ready  input  1  consumer accepts the word; a transfer occurs on an edge where Dump_Valid and Dump_Ready are both 1.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-017 The FSM SHALL have states IDLE, READ, SEND and DONE.
REQ-018 IDLE: when Start=1 and Abort=0, the block SHALL latch First_Reg as cur and Last_Reg as last, drive Read_Register=First_Reg, and enter READ.
REQ-019 READ (exactly one cycle): the block SHALL capture Read_Data into Dump_Data, set Dump_Addr=cur and Dump_Valid=1, and enter SEND.
REQ-020 SEND: while Dump_Ready=0, the block SHALL hold Dump_Data, Dump_Addr and Dump_Valid stable.
REQ-021 SEND, on transfer with cur==last: the block SHALL clear Dump_Valid and enter DONE.
REQ-022 SEND, on transfer with cur!=last: the block SHALL clear Dump_Valid, set cur and Read_Register to cur+1 modulo 2^ADDR_W, and enter READ.
REQ-023 DONE: Done SHALL be 1 for exactly one cycle; the FSM then returns to IDLE.
REQ-024 Wrap-around: if Last_Reg < First_Reg, the sequence SHALL run First..2^ADDR_W-1 and then 0..Last_Reg.
REQ-025 Word count SHALL be ((Last_Reg - First_Reg) mod 2^ADDR_W) + 1; if First_Reg == Last_Reg, exactly one word is dumped.
REQ-026 Latency: with Start sampled at edge k, Dump_Valid SHALL be 1 after edge k+1.
REQ-027 Maximum throughput SHALL be one word per two cycles, achieved when Dump_Ready is held at 1.
REQ-028 Start while Busy=1 SHALL be ignored; First_Reg and Last_Reg are not re-sampled.
REQ-029 Abort=1 in any state SHALL force IDLE at the next edge, with Dump_Valid=0, and SHALL suppress Done for that dump.
REQ-030 Abort and Start asserted together in IDLE: Abort SHALL win and no dump starts.
REQ-031 Read_Register SHALL hold its last value in IDLE.
REQ-032 The block SHALL never write the bank; register 0 is dumped like any other register.

Reset
REQ-033 While reset_n=0, the block SHALL immediately (asynchronously) set state=IDLE and Read_Register=0, Dump_Data=0, Dump_Addr=0, Dump_Valid=0, Busy=0, Done=0.
REQ-034 Reset mid-dump SHALL discard the dump; after release, the block SHALL require a new Start.

Verification
REQ-035 First=2, Last=4, Dump_Ready tied to 1, bank regs 2..4 = 0xA,0xB,0xC -> three transfers (2,0xA),(3,0xB),(4,0xC) on alternate cycles, then one Done pulse, then Busy=0.
REQ-036 First=62, Last=1 -> addresses 62,63,0,1 in that order, 4 words, then Done.
REQ-037 First=Last=5, Dump_Ready held 0 for 3 cycles -> Dump_Valid high and Dump_Data/Dump_Addr stable for all 3 cycles; one transfer, then Done.
REQ-038 Abort asserted while in SEND on the second word of 0..7 -> IDLE next cycle, Dump_Valid=0, no Done; a new Start with First=0, Last=0 dumps one word.
REQ-039 Start pulsed again mid-dump with different First/Last -> ignored; original sequence completes unchanged.
REQ-040 reset_n driven low mid-dump without a clock edge -> all outputs 0 immediately; after release, no activity until Start.

Source files
------------

// File: rtl/registers_dump_if.sv
// rtl/registers_dump_if.sv - bank read port and dump stream handshake bundle
interface registers_dump_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] read_register;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_valid;
  logic              dump_ready;

  modport master (
    output read_register,
    input  read_data,
    output dump_data,
    output dump_addr,
    output dump_valid,
    input  dump_ready
  );

  modport slave (
    input  read_register,
    output read_data,
    input  dump_data,
    input  dump_addr,
    input  dump_valid,
    output dump_ready
  );
endinterface

// File: rtl/registers_dump.sv
// rtl/registers_dump.sv - walks a register range and streams each value out
module registers_dump #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              done,
  registers_dump_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;
  logic              xfer;

  assign xfer = bus.dump_valid && bus.dump_ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection; abort overrides every other transition
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: if (start) state_next = READ;
      READ: state_next = SEND;
      SEND: begin
        if (xfer) begin
          state_next = (cur == last) ? DONE : READ;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // Address walk and output word capture; read address wraps naturally at 2^ADDR_W
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur               <= '0;
      last              <= '0;
      bus.read_register <= '0;
      bus.dump_data     <= '0;
      bus.dump_addr     <= '0;
      bus.dump_valid    <= 1'b0;
    end else if (abort) begin
      bus.dump_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur               <= first_reg;
            last              <= last_reg;
            bus.read_register <= first_reg;
          end
        end
        READ: begin
          bus.dump_data  <= bus.read_data;
          bus.dump_addr  <= cur;
          bus.dump_valid <= 1'b1;
        end
        SEND: begin
          if (xfer) begin
            bus.dump_valid <= 1'b0;
            if (cur != last) begin
              cur               <= cur + ADDR_W'(1);
              bus.read_register <= cur + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
